// File: rtl/am29xx_slice_pair.sv
// am29xx_slice_pair
//   One Am2901-compatible 4-bit ALU slice plus one microprogram sequencer
//   slice. The sequencer behaves as an Am2909 when AM2909_OR_INPUTS_EN is
//   defined, and as an Am2911 otherwise: AR loads from seq_din, and
//   seq_rin/seq_orin are kept as pins but ignored.
//
// Ports
//   clock, reset         rising-edge clock, async active-high reset
//   alu_din/a/b          D operand, RAM A read address, RAM B read/write address
//   alu_src/op/dest      I2:0 operand select, I5:3 function, I8:6 destination
//   alu_cin              ALU carry in
//   alu_y/cout/f0/f3/ovr ALU output, carry out, F==0, F[3], overflow
//   seq_din/rin/orin     direct address, AR load data, OR mask
//   seq_s0/s1            address source select
//   seq_zero_n           low forces seq_y to 0
//   seq_cin              incrementer carry in
//   seq_re_n/fe_n        AR load enable, stack enable (active low)
//   seq_pup              1 = push, 0 = pop
//   seq_y/cout           microaddress, incrementer carry out
module am29xx_slice_pair #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] alu_din,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    input  logic [2:0] alu_src,
    input  logic [2:0] alu_op,
    input  logic [2:0] alu_dest,
    input  logic       alu_cin,
    output logic [3:0] alu_y,
    output logic       alu_cout,
    output logic       alu_f0,
    output logic       alu_f3,
    output logic       alu_ovr,
    input  logic [3:0] seq_din,
    input  logic [3:0] seq_rin,
    input  logic [3:0] seq_orin,
    input  logic       seq_s0,
    input  logic       seq_s1,
    input  logic       seq_zero_n,
    input  logic       seq_cin,
    input  logic       seq_re_n,
    input  logic       seq_fe_n,
    input  logic       seq_pup,
    output logic [3:0] seq_y,
    output logic       seq_cout
);
    localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // ------------------------------------------------------------------
    // ALU slice
    // ------------------------------------------------------------------
    logic [3:0] ram [16];
    logic [3:0] q;
    logic [3:0] rd_a, rd_b;
    logic [3:0] r, s, op_r, op_s, f;
    logic [4:0] sum;
    logic [3:0] low_sum;
    logic       arith;
    logic       ram_we, q_we;
    logic [3:0] b_wdata, q_next;

    assign rd_a = ram[alu_a];
    assign rd_b = ram[alu_b];

    always_comb begin
        r = '0;
        s = '0;
        case (alu_src)
            3'd0: begin r = rd_a;    s = q;    end
            3'd1: begin r = rd_a;    s = rd_b; end
            3'd2: begin r = '0;      s = q;    end
            3'd3: begin r = '0;      s = rd_b; end
            3'd4: begin r = '0;      s = rd_a; end
            3'd5: begin r = alu_din; s = rd_a; end
            3'd6: begin r = alu_din; s = q;    end
            default: begin r = alu_din; s = '0; end
        endcase
    end

    // Subtractions are done as one's-complement plus carry-in, so a single
    // adder serves all three arithmetic functions.
    always_comb begin
        op_r = r;
        op_s = s;
        if (alu_op == 3'd1) op_r = ~r;
        if (alu_op == 3'd2) op_s = ~s;
    end

    assign arith   = (alu_op < 3'd3);
    assign sum     = {1'b0, op_r} + {1'b0, op_s} + {4'b0, alu_cin};
    // Low three bits summed separately to recover the carry into bit 3.
    assign low_sum = {1'b0, op_r[2:0]} + {1'b0, op_s[2:0]} + {3'b0, alu_cin};

    always_comb begin
        f = '0;
        case (alu_op)
            3'd3:    f = r | s;
            3'd4:    f = r & s;
            3'd5:    f = ~r & s;
            3'd6:    f = r ^ s;
            3'd7:    f = ~(r ^ s);
            default: f = sum[3:0];
        endcase
    end

    assign alu_cout = arith & sum[4];
    assign alu_ovr  = arith & (sum[4] ^ low_sum[3]);
    assign alu_f0   = (f == 4'h0);
    assign alu_f3   = f[3];
    assign alu_y    = (alu_dest == 3'd2) ? rd_a : f;

    always_comb begin
        ram_we  = alu_dest[2] | alu_dest[1];
        q_we    = 1'b0;
        b_wdata = f;
        q_next  = q;
        case (alu_dest)
            3'd0: begin q_we = 1'b1; q_next = f; end
            3'd4: begin
                b_wdata = {1'b0, f[3:1]};
                q_we    = 1'b1;
                q_next  = {1'b0, q[3:1]};
            end
            3'd5: b_wdata = {1'b0, f[3:1]};
            3'd6: begin
                b_wdata = {f[2:0], 1'b0};
                q_we    = 1'b1;
                q_next  = {q[2:0], 1'b0};
            end
            3'd7: b_wdata = {f[2:0], 1'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
            q <= '0;
        end else begin
            if (ram_we) ram[alu_b] <= b_wdata;
            if (q_we)   q <= q_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer slice
    // ------------------------------------------------------------------
    logic [3:0]     upc, ar, seq_mux, or_mask, ar_src, stack_top;
    logic [3:0]     stack [STACK_DEPTH];
    logic [SPW-1:0] sp, sp_inc, sp_dec;

`ifdef AM2909_OR_INPUTS_EN
    assign or_mask = seq_orin;
    assign ar_src  = seq_rin;
`else
    assign or_mask = 4'h0;
    assign ar_src  = seq_din;
    // rin/orin remain as pins for board compatibility only.
    logic unused_pins;
    assign unused_pins = ^{seq_rin, seq_orin};
`endif

    // SP width matches the power-of-2 depth, so natural wrap is modulo depth.
    assign sp_inc    = sp + SPW'(1);
    assign sp_dec    = sp - SPW'(1);
    assign stack_top = stack[sp];

    always_comb begin
        seq_mux = upc;
        case ({seq_s1, seq_s0})
            2'd1:    seq_mux = ar;
            2'd2:    seq_mux = stack_top;
            2'd3:    seq_mux = seq_din;
            default: seq_mux = upc;
        endcase
    end

    assign seq_y    = (reset | ~seq_zero_n) ? 4'h0 : (seq_mux | or_mask);
    assign seq_cout = seq_cin & (seq_y == 4'hF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upc <= '0;
            ar  <= '0;
        end else begin
            upc <= seq_y + {3'b0, seq_cin};
            if (!seq_re_n) ar <= ar_src;
        end
    end

    // Push stores the uPC as it stands before this edge's increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else if (!seq_fe_n) begin
            if (seq_pup) begin
                sp            <= sp_inc;
                stack[sp_inc] <= upc;
            end else begin
                sp <= sp_dec;
            end
        end
    end

endmodule

// File: tb/tb_am29xx_slice_pair.sv
module tb_am29xx_slice_pair;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] alu_din, alu_a, alu_b;
    logic [2:0] alu_src, alu_op, alu_dest;
    logic       alu_cin;
    logic [3:0] alu_y;
    logic       alu_cout, alu_f0, alu_f3, alu_ovr;
    logic [3:0] seq_din, seq_rin, seq_orin;
    logic       seq_s0, seq_s1, seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup;
    logic [3:0] seq_y;
    logic       seq_cout;

    int errors = 0;
    int checks = 0;

    // reference state, plain integers
    int m_ram [16];
    int m_stk [DEPTH];
    int m_q, m_upc, m_ar, m_sp;
    int e_f, e_y, e_cout, e_ovr, e_sy, e_scout;

    am29xx_slice_pair #(.STACK_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b),
        .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest),
        .alu_cin(alu_cin), .alu_y(alu_y), .alu_cout(alu_cout),
        .alu_f0(alu_f0), .alu_f3(alu_f3), .alu_ovr(alu_ovr),
        .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin),
        .seq_s0(seq_s0), .seq_s1(seq_s1), .seq_zero_n(seq_zero_n),
        .seq_cin(seq_cin), .seq_re_n(seq_re_n), .seq_fe_n(seq_fe_n),
        .seq_pup(seq_pup), .seq_y(seq_y), .seq_cout(seq_cout)
    );

    always #5 clock = ~clock;

    function automatic int sx(int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_ram[i] = 0;
        for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
        m_q = 0; m_upc = 0; m_ar = 0; m_sp = 0;
    endfunction

    function automatic void model_eval();
        int r, s, rr, ss, full, sgn, mux, orm;
        case (int'(alu_src))
            0: begin r = m_ram[alu_a]; s = m_q; end
            1: begin r = m_ram[alu_a]; s = m_ram[alu_b]; end
            2: begin r = 0; s = m_q; end
            3: begin r = 0; s = m_ram[alu_b]; end
            4: begin r = 0; s = m_ram[alu_a]; end
            5: begin r = int'(alu_din); s = m_ram[alu_a]; end
            6: begin r = int'(alu_din); s = m_q; end
            default: begin r = int'(alu_din); s = 0; end
        endcase
        if (int'(alu_op) < 3) begin
            rr   = (int'(alu_op) == 1) ? 15 - r : r;
            ss   = (int'(alu_op) == 2) ? 15 - s : s;
            full = rr + ss + int'(alu_cin);
            sgn  = sx(rr) + sx(ss) + int'(alu_cin);
            e_f    = full % 16;
            e_cout = (full >= 16) ? 1 : 0;
            e_ovr  = (sgn > 7 || sgn < -8) ? 1 : 0;
        end else begin
            e_cout = 0;
            e_ovr  = 0;
            case (int'(alu_op))
                3: e_f = r | s;
                4: e_f = r & s;
                5: e_f = (15 - r) & s;
                6: e_f = r ^ s;
                default: e_f = 15 - (r ^ s);
            endcase
        end
        e_y = (int'(alu_dest) == 2) ? m_ram[alu_a] : e_f;

        case ({seq_s1, seq_s0})
            2'd0: mux = m_upc;
            2'd1: mux = m_ar;
            2'd2: mux = m_stk[m_sp];
            default: mux = int'(seq_din);
        endcase
`ifdef AM2909_OR_INPUTS_EN
        orm = int'(seq_orin);
`else
        orm = 0;
`endif
        e_sy    = (reset || !seq_zero_n) ? 0 : (mux | orm);
        e_scout = (seq_cin && e_sy == 15) ? 1 : 0;
    endfunction

    function automatic void model_update();
        int b;
        b = int'(alu_b);
        case (int'(alu_dest))
            0: m_q = e_f;
            2, 3: m_ram[b] = e_f;
            4: begin m_ram[b] = e_f / 2; m_q = m_q / 2; end
            5: m_ram[b] = e_f / 2;
            6: begin m_ram[b] = (e_f * 2) % 16; m_q = (m_q * 2) % 16; end
            7: m_ram[b] = (e_f * 2) % 16;
            default: ;
        endcase
        if (!seq_fe_n) begin
            if (seq_pup) begin
                m_sp = (m_sp + 1) % DEPTH;
                m_stk[m_sp] = m_upc;
            end else begin
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
            end
        end
`ifdef AM2909_OR_INPUTS_EN
        if (!seq_re_n) m_ar = int'(seq_rin);
`else
        if (!seq_re_n) m_ar = int'(seq_din);
`endif
        m_upc = (e_sy + int'(seq_cin)) % 16;
    endfunction

    task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, sampled 1 time unit after
    // inputs change (well clear of the rising edge).
    task automatic look(string tag);
        #1;
        if (reset) model_clear();
        model_eval();
        check({tag, "/alu_y"},    alu_y,              4'(e_y));
        check({tag, "/alu_cout"}, {3'b0, alu_cout},   4'(e_cout));
        check({tag, "/alu_ovr"},  {3'b0, alu_ovr},    4'(e_ovr));
        check({tag, "/alu_f0"},   {3'b0, alu_f0},     4'((e_f == 0) ? 1 : 0));
        check({tag, "/alu_f3"},   {3'b0, alu_f3},     4'((e_f >= 8) ? 1 : 0));
        check({tag, "/seq_y"},    seq_y,              4'(e_sy));
        check({tag, "/seq_cout"}, {3'b0, seq_cout},   4'(e_scout));
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_update();
        @(negedge clock);
    endtask

    task automatic alu_set(int src, int op, int dest, int din, int a, int b, int cin);
        alu_src = 3'(src); alu_op = 3'(op); alu_dest = 3'(dest);
        alu_din = 4'(din); alu_a = 4'(a); alu_b = 4'(b); alu_cin = 1'(cin);
    endtask

    task automatic seq_set(int sel, int din, int cin, int fe_n, int pup);
        {seq_s1, seq_s0} = 2'(sel);
        seq_din = 4'(din); seq_cin = 1'(cin);
        seq_fe_n = 1'(fe_n); seq_pup = 1'(pup);
    endtask

    initial begin
        reset = 1'b0;
        alu_set(7, 0, 1, 5, 0, 0, 0);
        seq_set(3, 15, 1, 1, 0);
        seq_rin = 4'h0; seq_orin = 4'h0; seq_zero_n = 1'b1; seq_re_n = 1'b1;
        model_clear();
        #2 reset = 1'b1;
        @(negedge clock);

        // reset held: sequencer output forced low even with D=F, cin=1
        look("reset");
        check("reset_seq_y", seq_y, 4'h0);
        check("reset_seq_cout", {3'b0, seq_cout}, 4'h0);
        tick();
        reset = 1'b0;
        seq_set(0, 0, 0, 1, 0);

        // D+0 passthrough
        alu_set(7, 0, 1, 5, 0, 0, 0);
        look("d_add");
        check("d_add_y", alu_y, 4'h5);
        check("d_add_f0", {3'b0, alu_f0}, 4'h0);
        tick();

        // write R2 = 9, read it back through S+~R+cin with R=0
        alu_set(7, 0, 3, 9, 0, 2, 0);
        look("wr_r2");
        tick();
        alu_set(3, 1, 1, 0, 0, 2, 1);
        look("sub_r2");
        check("sub_r2_y", alu_y, 4'h9);
        tick();
        alu_set(1, 0, 1, 0, 2, 2, 0);
        look("add_wrap");
        check("add_wrap_y", alu_y, 4'h2);
        check("add_wrap_cout", {3'b0, alu_cout}, 4'h1);
        check("add_wrap_ovr", {3'b0, alu_ovr}, 4'h1);
        tick();

        // zero result with carry out
        alu_set(7, 1, 1, 0, 0, 0, 1);
        look("zero");
        check("zero_f0", {3'b0, alu_f0}, 4'h1);
        check("zero_cout", {3'b0, alu_cout}, 4'h1);
        tick();

        // write and read same RAM word in one cycle: old value seen first
        alu_set(1, 0, 3, 0, 2, 2, 0);
        look("wr_same");
        check("wr_same_y", alu_y, 4'h2);
        tick();
        alu_set(3, 0, 2, 0, 2, 5, 0);
        look("after_wr");
        check("after_wr_y", alu_y, 4'h2);
        tick();
        // shift destinations through Q
        alu_set(7, 0, 0, 11, 0, 0, 0);
        look("q_load"); tick();
        alu_set(2, 0, 4, 0, 0, 7, 0);
        look("q_shr"); tick();
        alu_set(2, 0, 6, 0, 0, 8, 0);
        look("q_shl"); tick();
        alu_set(0, 6, 1, 0, 7, 0, 0);
        look("q_read"); tick();

        // sequencer counting from reset
        alu_set(7, 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        look("seq_rst"); tick();
        reset = 1'b0;
        seq_set(0, 0, 1, 1, 0);
        for (int i = 0; i < 17; i++) begin
            look("count");
            check("count_y", seq_y, 4'(i % 16));
            check("count_cout", {3'b0, seq_cout}, (i == 15) ? 4'h1 : 4'h0);
            tick();
        end
        look("cnt1"); tick();
        look("cnt2"); tick();

        // push at uPC=3, jump to 8, read stack top, pop
        seq_set(0, 0, 1, 0, 1);
        look("push");
        check("push_y", seq_y, 4'h3);
        tick();
        seq_set(3, 8, 1, 1, 0);
        look("jump");
        check("jump_y", seq_y, 4'h8);
        tick();
        seq_set(2, 0, 1, 1, 0);
        look("top");
        check("top_y", seq_y, 4'h3);
        tick();
        seq_set(2, 0, 1, 0, 0);
        look("pop");
        check("pop_y", seq_y, 4'h3);
        tick();
        seq_set(2, 0, 1, 1, 0);
        look("post_pop");
        check("post_pop_y", seq_y, 4'h0);
        tick();

        // OR mask and forced zero
        seq_orin = 4'b0010;
        seq_set(3, 4, 0, 1, 0);
        look("or_mask");
`ifdef AM2909_OR_INPUTS_EN
        check("or_mask_y", seq_y, 4'h6);
`else
        check("or_mask_y", seq_y, 4'h4);
`endif
        seq_zero_n = 1'b0;
        look("zero_n");
        check("zero_n_y", seq_y, 4'h0);
        tick();
        seq_zero_n = 1'b1;
        seq_orin = 4'h0;

        // AR load then select
        seq_rin = 4'hA; seq_re_n = 1'b0;
        seq_set(3, 5, 0, 1, 0);
        look("ar_load"); tick();
        seq_re_n = 1'b1;
        seq_set(1, 0, 0, 1, 0);
        look("ar_sel");
`ifdef AM2909_OR_INPUTS_EN
        check("ar_sel_y", seq_y, 4'hA);
`else
        check("ar_sel_y", seq_y, 4'h5);
`endif
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            alu_din    = 4'($urandom); alu_a = 4'($urandom); alu_b = 4'($urandom);
            alu_src    = 3'($urandom); alu_op = 3'($urandom); alu_dest = 3'($urandom);
            alu_cin    = 1'($urandom);
            seq_din    = 4'($urandom); seq_rin = 4'($urandom); seq_orin = 4'($urandom);
            seq_s0     = 1'($urandom); seq_s1 = 1'($urandom);
            seq_zero_n = ($urandom_range(0, 7) != 0);
            seq_cin    = 1'($urandom); seq_re_n = 1'($urandom);
            seq_fe_n   = 1'($urandom); seq_pup = 1'($urandom);
            look("rand");
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
